seq_scan_ctrl: RTL and testbench

//   Frame-level controller for bit-serial pattern detection. Accepts WORD_W-bit words over valid/ready,

---
 rtl/seq_scan_ctrl_pkg.sv | 12 +
 rtl/seq_scan_ctrl_if.sv | 44 ++++
 rtl/seq_scan_ctrl_det.sv | 49 ++++
 rtl/seq_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_seq_scan_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types and constants for the seq_scan_ctrl frame scanner.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [3:0] PATTERN_1010 = 4'b1010;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word-in / count-out handshake bundle for seq_scan_ctrl.
// out_sat exists only when SEQ_SCAN_SAT_EN is defined.
interface seq_scan_ctrl_if #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
`ifdef SEQ_SCAN_SAT_EN
    logic              out_sat;
`endif

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
`ifdef SEQ_SCAN_SAT_EN
        output out_sat,
`endif
        output out_count
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
`ifdef SEQ_SCAN_SAT_EN
        input  out_sat,
`endif
        input  out_count
    );

endinterface

// File: rtl/seq_scan_ctrl_det.sv
// Enable-gated overlapping serial pattern detector with sync clear.
module seq_det_core
    import seq_scan_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_1010)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic x,
    output logic z
);

    localparam int               SEEN_W   = $clog2(PAT_W);
    localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [SEEN_W-1:0] seen_q, seen_d;
    logic [PAT_W-1:0]  win;

    assign win = {hist_q, x};
    assign z   = en && (win == PATTERN) && (seen_q == SEEN_MAX);

    always_comb begin
        hist_d = hist_q;
        seen_d = seen_q;
        if (clr) begin
            hist_d = '0;
            seen_d = '0;
        end else if (en) begin
            hist_d = win[PAT_W-2:0];
            if (seen_q != SEEN_MAX)
                seen_d = seen_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            seen_q <= '0;
        end else begin
            hist_q <= hist_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame controller: shifts words MSB-first into seq_det_core, reports match count.
// Optional SEQ_SCAN_SAT_EN adds the out_sat saturation flag.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int               WORD_W  = 16,
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_1010),
    parameter int               CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_scan_ctrl_if.slave  bus
);

    localparam int               IDX_W   = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              open_q, open_d;
`ifdef SEQ_SCAN_SAT_EN
    logic              sat_q, sat_d;
`endif

    logic det_en;
    logic det_clr;
    logic det_x;
    logic det_z;

    assign det_x         = word_q[idx_q];
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == REPORT);
    assign bus.out_count = cnt_q;
`ifdef SEQ_SCAN_SAT_EN
    assign bus.out_sat   = sat_q;
`endif

    seq_det_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_det (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (det_en),
        .clr   (det_clr),
        .x     (det_x),
        .z     (det_z)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        last_d  = last_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        open_d  = open_q;
`ifdef SEQ_SCAN_SAT_EN
        sat_d   = sat_q;
`endif
        det_en  = 1'b0;
        det_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
                    last_d  = bus.in_last;
                    idx_d   = IDX_W'(WORD_W - 1);
                    state_d = SHIFT;
                    // first word of a frame: wipe detector history and count
                    if (!open_q) begin
                        det_clr = 1'b1;
                        cnt_d   = '0;
                        open_d  = 1'b1;
`ifdef SEQ_SCAN_SAT_EN
                        sat_d   = 1'b0;
`endif
                    end
                end
            end
            SHIFT: begin
                det_en = 1'b1;
                if (det_z) begin
                    if (cnt_q == CNT_MAX) begin
`ifdef SEQ_SCAN_SAT_EN
                        sat_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) begin
                    if (last_q) begin
                        state_d = REPORT;
                        open_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            REPORT: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            open_q  <= 1'b0;
`ifdef SEQ_SCAN_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            open_q  <= open_d;
`ifdef SEQ_SCAN_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: two DUTs (CNT_W=8 and CNT_W=2) share stimulus.
module tb_seq_scan_ctrl;

    localparam int         W   = 8;
    localparam int         PW  = 4;
    localparam logic [3:0] PAT = 4'b1010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_scan_ctrl_if #(.WORD_W(W), .CNT_W(8)) if8 ();
    seq_scan_ctrl_if #(.WORD_W(W), .CNT_W(2)) if2 ();

    assign if2.in_valid  = if8.in_valid;
    assign if2.in_data   = if8.in_data;
    assign if2.in_last   = if8.in_last;
    assign if2.out_ready = if8.out_ready;

    seq_scan_ctrl #(.WORD_W(W), .PAT_W(PW), .PATTERN(PAT), .CNT_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    seq_scan_ctrl #(.WORD_W(W), .PAT_W(PW), .PATTERN(PAT), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int raw_q[$];
    int lat_q[$];
    bit fbits[$];
    bit hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: count every window of the frame's bit stream equal to the pattern.
    function automatic int count_matches();
        int n = 0;
        logic [3:0] p = PAT;
        for (int i = PW - 1; i < fbits.size(); i++) begin
            bit ok = 1'b1;
            for (int k = 0; k < PW; k++)
                if (fbits[i-PW+1+k] != p[PW-1-k]) ok = 1'b0;
            if (ok) n++;
        end
        return n;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic send(input logic [7:0] d, input bit last, input bit track);
        int t = 0;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b1;
        if8.in_data  = d;
        if8.in_last  = last;
        @(negedge clk);
        while (!if8.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", int'(t < 200), 1);
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        if8.in_data  = 8'($urandom);
        if8.in_last  = 1'($urandom);
        if (track) begin
            for (int k = W - 1; k >= 0; k--) fbits.push_back(d[k]);
            if (last) begin
                raw_q.push_back(count_matches());
                lat_q.push_back(cyc + W);
                fbits.delete();
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((raw_q.size() != 0 || if8.out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", raw_q.size(), 0);
    endtask

    initial begin
        if8.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if8.out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency, ordering, stability and backpressure of the result port.
    initial begin
        bit ov_prev = 1'b0;
        bit pend = 1'b0;
        bit hs_prev = 1'b0;
        int held = 0;
        int raw;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ov_prev = 1'b0;
                pend    = 1'b0;
                hs_prev = 1'b0;
            end else begin
                if (hs_prev) begin
                    chk("idle_after_hs", int'(if8.in_ready), 1);
                    chk("valid_drop", int'(if8.out_valid), 0);
                end
                hs_prev = 1'b0;
                chk("valid_pair", int'(if2.out_valid), int'(if8.out_valid));
                if (if8.out_valid && !ov_prev) begin
                    if (lat_q.size() > 0)
                        chk("latency", cyc, lat_q.pop_front());
                    else
                        chk("unexpected_valid", lat_q.size(), 1);
                end
                if (if8.out_valid) begin
                    chk("in_ready_low", int'(if8.in_ready), 0);
                    if (pend) chk("count_stable", int'(if8.out_count), held);
                    if (if8.out_ready) begin
                        if (raw_q.size() > 0) begin
                            raw = raw_q.pop_front();
                            chk("count_w8", int'(if8.out_count), min_i(raw, 255));
                            chk("count_w2", int'(if2.out_count), min_i(raw, 3));
`ifdef SEQ_SCAN_SAT_EN
                            chk("sat_w8", int'(if8.out_sat), int'(raw > 255));
                            chk("sat_w2", int'(if2.out_sat), int'(raw > 3));
`endif
                        end else begin
                            chk("scoreboard_empty", raw_q.size(), 1);
                        end
                        pend    = 1'b0;
                        hs_prev = 1'b1;
                    end else begin
                        pend = 1'b1;
                        held = int'(if8.out_count);
                    end
                end
                ov_prev = if8.out_valid;
            end
        end
    end

    initial begin
        int t;
        if8.in_valid = 1'b0;
        if8.in_data  = '0;
        if8.in_last  = 1'b0;
        #12;
        chk("rst_in_ready", int'(if8.in_ready), 1);
        chk("rst_out_valid", int'(if8.out_valid), 0);
        chk("rst_out_count", int'(if8.out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        send(8'b1010_1010, 1'b1, 1'b1);
        send(8'b0000_0101, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        send(8'b0000_0000, 1'b1, 1'b1);
        send(8'b0000_0101, 1'b1, 1'b1);
        send(8'b0000_0000, 1'b1, 1'b1);
        send(8'hAA, 1'b0, 1'b1);
        send(8'hAA, 1'b1, 1'b1);
        drain();

        hold = 1'b1;
        send(8'h5A, 1'b1, 1'b1);
        t = 0;
        while (!if8.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("hold_valid_seen", int'(if8.out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", int'(if8.out_valid), 1);
        end
        hold = 1'b0;
        drain();

        for (int f = 0; f < 40; f++) begin
            int nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                logic [7:0] d;
                d = ($urandom_range(0, 2) == 0) ? 8'hAA : 8'($urandom);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                send(d, w == nw - 1, 1'b1);
            end
        end
        drain();

        send(8'hAA, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(if8.out_valid), 0);
        chk("midrst_count_w8", int'(if8.out_count), 0);
        chk("midrst_count_w2", int'(if2.out_count), 0);
        chk("midrst_in_ready", int'(if8.in_ready), 1);
`ifdef SEQ_SCAN_SAT_EN
        chk("midrst_sat", int'(if2.out_sat), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        send(8'hAA, 1'b1, 1'b1);
        drain();
        chk("lat_q_empty", lat_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
